// File: rtl/adma_dm_bresp_tracker_pkg.sv
// Shared definitions for the DMA data-mover write-response tracker:
// BRESP encodings and the error classifier.
package adma_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } bresp_e;

   // SLVERR and DECERR both have the upper bit set.
   function automatic logic is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/adma_dm_bresp_tracker_if.sv
// AW-issue allocation handshake plus AXI B channel between the data mover
// (master side) and the write-response tracker (slave side).
interface adma_dm_bresp_tracker_if #(
   parameter int MST_ID_W      = 5,
   parameter int DMA_CHN_NUM_W = 2,
   parameter int ATX_RESP_W    = 2
);
   logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
   logic [MST_ID_W-1:0]      atx_awid;
   logic                     atx_vld;
   logic                     atx_rdy;
   logic [MST_ID_W-1:0]      m_bid_i;
   logic [ATX_RESP_W-1:0]    m_bresp_i;
   logic                     m_bvalid_i;
   logic                     m_bready_o;

   modport master (
      output atx_chn_id, atx_awid, atx_vld, m_bid_i, m_bresp_i, m_bvalid_i,
      input  atx_rdy, m_bready_o
   );

   modport slave (
      input  atx_chn_id, atx_awid, atx_vld, m_bid_i, m_bresp_i, m_bvalid_i,
      output atx_rdy, m_bready_o
   );
endinterface

// File: rtl/adma_dm_bresp_tracker_match.sv
// Combinational priority matcher: finds the lowest-index (oldest) valid
// entry whose ID equals the incoming BID.
module adma_bresp_match #(
   parameter int N    = 8,
   parameter int ID_W = 5,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]           vld,
   input  logic [N-1:0][ID_W-1:0] ids,
   input  logic [ID_W-1:0]        bid,
   output logic                   hit,
   output logic [N-1:0]           onehot,
   output logic [IDX_W-1:0]       idx
);
   logic [N-1:0] eq;

   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_eq
      assign eq[gi] = vld[gi] && (ids[gi] == bid);
   end

   assign hit    = |eq;
   // Isolate the lowest set bit.
   assign onehot = eq & (~eq + N'(1));

   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eq[i]) idx = IDX_W'(i);
      end
   end
endmodule

// File: rtl/adma_dm_bresp_tracker.sv
// AXI B-channel tracker: ordered collapsing table of outstanding AW transactions,
// matched by BID. Optional per-entry age timeout under ADMA_BRESP_TIMEOUT_EN.
module adma_dm_bresp_tracker
   import adma_pkg::*;
#(
   parameter int DMA_CHN_NUM  = 4,
   parameter int MST_ID_W     = 5,
   parameter int ATX_RESP_W   = 2,
   parameter int ATX_NUM_OSTD = 8,
   parameter int TIMEOUT_W    = 16,
   localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
   localparam int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   adma_dm_bresp_tracker_if.slave bus,
   output logic [DMA_CHN_NUM-1:0] atx_done,
   output logic [DMA_CHN_NUM-1:0] atx_dst_err,
   output logic [ATX_RESP_W-1:0]  atx_resp,
   output logic [DMA_CHN_NUM-1:0] chn_busy,
   output logic                   unexp_bid,
   output logic [DMA_CHN_NUM-1:0] atx_timeout
);
   localparam int IDX_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
   localparam int LAST  = ATX_NUM_OSTD - 1;

   typedef struct packed {
      logic                     vld;
      logic [MST_ID_W-1:0]      id;
      logic [DMA_CHN_NUM_W-1:0] chn;
   } entry_t;

   entry_t tbl_reg  [ATX_NUM_OSTD];
   entry_t tbl_sh   [ATX_NUM_OSTD];
   entry_t tbl_next [ATX_NUM_OSTD];

   logic [ATX_NUM_OSTD-1:0]               vld_vec;
   logic [ATX_NUM_OSTD-1:0][MST_ID_W-1:0] id_vec;
   logic [ATX_NUM_OSTD-1:0]               match_oh;
   logic [ATX_NUM_OSTD-1:0]               shift_mask;
   logic [IDX_W-1:0]                      match_idx;
   logic                                  match_hit;

   logic [OSTD_CNT_W-1:0]    cnt_reg;
   logic [OSTD_CNT_W-1:0]    cnt_coll;
   logic                     bready_reg;
   logic                     atx_rdy_w;
   logic                     alloc;
   logic                     retire;
   logic                     rm;
   logic [DMA_CHN_NUM_W-1:0] ret_chn;

   logic [DMA_CHN_NUM-1:0] done_reg;
   logic [DMA_CHN_NUM-1:0] err_reg;
   logic [ATX_RESP_W-1:0]  resp_reg;
   logic                   unexp_reg;

   assign atx_rdy_w      = (cnt_reg != OSTD_CNT_W'(ATX_NUM_OSTD));
   assign bus.atx_rdy    = atx_rdy_w;
   assign bus.m_bready_o = bready_reg;

   assign alloc  = bus.atx_vld & atx_rdy_w;
   assign retire = bus.m_bvalid_i & bready_reg;
   assign rm     = retire & match_hit;

   // Entries at or above the retired slot take their younger neighbour's contents.
   assign shift_mask = rm ? ~(match_oh - ATX_NUM_OSTD'(1)) : '0;
   assign cnt_coll   = cnt_reg - OSTD_CNT_W'(rm);
   assign ret_chn    = tbl_reg[match_idx].chn;

   genvar gi;
   for (gi = 0; gi < ATX_NUM_OSTD; gi++) begin : g_vec
      assign vld_vec[gi] = tbl_reg[gi].vld;
      assign id_vec[gi]  = tbl_reg[gi].id;
   end

   adma_bresp_match #(
      .N    (ATX_NUM_OSTD),
      .ID_W (MST_ID_W)
   ) u_match (
      .vld    (vld_vec),
      .ids    (id_vec),
      .bid    (bus.m_bid_i),
      .hit    (match_hit),
      .onehot (match_oh),
      .idx    (match_idx)
   );

   // Matching uses tbl_reg only, so the entry allocated this cycle cannot be hit.
   always_comb begin
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
         if (!shift_mask[i])  tbl_sh[i] = tbl_reg[i];
         else if (i == LAST)  tbl_sh[i] = '0;
         else                 tbl_sh[i] = tbl_reg[(i == LAST) ? i : i + 1];
         tbl_next[i] = tbl_sh[i];
         if (alloc && (cnt_coll == OSTD_CNT_W'(i))) begin
            tbl_next[i].vld = 1'b1;
            tbl_next[i].id  = bus.atx_awid;
            tbl_next[i].chn = bus.atx_chn_id;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ATX_NUM_OSTD; i++) tbl_reg[i] <= '0;
         cnt_reg    <= '0;
         bready_reg <= 1'b0;
         done_reg   <= '0;
         err_reg    <= '0;
         resp_reg   <= '0;
         unexp_reg  <= 1'b0;
      end else begin
         for (int i = 0; i < ATX_NUM_OSTD; i++) tbl_reg[i] <= tbl_next[i];
         cnt_reg    <= cnt_coll + OSTD_CNT_W'(alloc);
         bready_reg <= 1'b1;
         done_reg   <= '0;
         err_reg    <= '0;
         if (rm) begin
            done_reg[ret_chn] <= 1'b1;
            err_reg[ret_chn]  <= is_err(bus.m_bresp_i);
         end
         resp_reg <= rm ? bus.m_bresp_i : '0;
         if (retire && !match_hit) unexp_reg <= 1'b1;
      end
   end

   for (gi = 0; gi < DMA_CHN_NUM; gi++) begin : g_chn
      logic [OSTD_CNT_W-1:0] chn_cnt_reg;
      logic                  inc;
      logic                  dec;

      assign inc = alloc && (bus.atx_chn_id == DMA_CHN_NUM_W'(gi));
      assign dec = rm && (ret_chn == DMA_CHN_NUM_W'(gi));

      always_ff @(posedge clk) begin
         if (rst)               chn_cnt_reg <= '0;
         else if (inc && !dec)  chn_cnt_reg <= chn_cnt_reg + OSTD_CNT_W'(1);
         else if (dec && !inc)  chn_cnt_reg <= chn_cnt_reg - OSTD_CNT_W'(1);
      end

      assign chn_busy[gi] = (chn_cnt_reg != '0);
   end

   assign atx_done    = done_reg;
   assign atx_dst_err = err_reg;
   assign atx_resp    = resp_reg;
   assign unexp_bid   = unexp_reg;

`ifdef ADMA_BRESP_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] AGE_MAX = '1;

   logic [TIMEOUT_W-1:0]   age_reg  [ATX_NUM_OSTD];
   logic [TIMEOUT_W-1:0]   age_next [ATX_NUM_OSTD];
   logic                   to_reg   [ATX_NUM_OSTD];
   logic                   to_next  [ATX_NUM_OSTD];
   logic [DMA_CHN_NUM-1:0] to_pulse;
   logic [DMA_CHN_NUM-1:0] timeout_reg;

   // Age and sticky flag follow the same collapse as the entry itself.
   always_comb begin
      to_pulse = '0;
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
         logic [TIMEOUT_W-1:0] a;
         logic [TIMEOUT_W-1:0] a_inc;
         logic                 t;
         a     = age_reg[i];
         t     = to_reg[i];
         a_inc = '0;
         if (shift_mask[i]) begin
            a = (i == LAST) ? '0   : age_reg[(i == LAST) ? i : i + 1];
            t = (i == LAST) ? 1'b0 : to_reg[(i == LAST) ? i : i + 1];
         end
         age_next[i] = '0;
         to_next[i]  = 1'b0;
         if (!(alloc && (cnt_coll == OSTD_CNT_W'(i))) && tbl_sh[i].vld) begin
            a_inc       = (a == AGE_MAX) ? a : a + TIMEOUT_W'(1);
            age_next[i] = a_inc;
            to_next[i]  = t | (a_inc == AGE_MAX);
            if ((a_inc == AGE_MAX) && !t) to_pulse[tbl_sh[i].chn] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ATX_NUM_OSTD; i++) begin
            age_reg[i] <= '0;
            to_reg[i]  <= 1'b0;
         end
         timeout_reg <= '0;
      end else begin
         for (int i = 0; i < ATX_NUM_OSTD; i++) begin
            age_reg[i] <= age_next[i];
            to_reg[i]  <= to_next[i];
         end
         timeout_reg <= to_pulse;
      end
   end

   assign atx_timeout = timeout_reg;
`else
   assign atx_timeout = '0;
`endif
endmodule

// File: tb/tb_adma_dm_bresp_tracker.sv
// Directed self-checking bench for adma_dm_bresp_tracker; the timeout section
// runs only when ADMA_BRESP_TIMEOUT_EN is defined (bench sets TIMEOUT_W=4).
module tb_adma_dm_bresp_tracker;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] atx_done;
   logic [3:0] atx_dst_err;
   logic [1:0] atx_resp;
   logic [3:0] chn_busy;
   logic       unexp_bid;
   logic [3:0] atx_timeout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   adma_dm_bresp_tracker_if #(.MST_ID_W(5), .DMA_CHN_NUM_W(2), .ATX_RESP_W(2)) bus ();

   adma_dm_bresp_tracker #(
      .DMA_CHN_NUM  (4),
      .MST_ID_W     (5),
      .ATX_RESP_W   (2),
      .ATX_NUM_OSTD (8),
      .TIMEOUT_W    (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .atx_done    (atx_done),
      .atx_dst_err (atx_dst_err),
      .atx_resp    (atx_resp),
      .chn_busy    (chn_busy),
      .unexp_bid   (unexp_bid),
      .atx_timeout (atx_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_alloc(input int ch, input int id);
      bus.atx_vld    = 1'b1;
      bus.atx_chn_id = 2'(ch);
      bus.atx_awid   = 5'(id);
      tick();
      bus.atx_vld    = 1'b0;
      $display("alloc ch=%0d id=%0d rdy=%0b busy=%b", ch, id, bus.atx_rdy, chn_busy);
   endtask

   task automatic do_b(input int id, input int resp);
      bus.m_bvalid_i = 1'b1;
      bus.m_bid_i    = 5'(id);
      bus.m_bresp_i  = 2'(resp);
      tick();
      bus.m_bvalid_i = 1'b0;
      $display("bresp id=%0d resp=%0d done=%b err=%b resp_o=%0d busy=%b unexp=%0b",
               id, resp, atx_done, atx_dst_err, atx_resp, chn_busy, unexp_bid);
   endtask

   task automatic do_both(input int ch, input int id, input int bid);
      bus.atx_vld    = 1'b1;
      bus.atx_chn_id = 2'(ch);
      bus.atx_awid   = 5'(id);
      bus.m_bvalid_i = 1'b1;
      bus.m_bid_i    = 5'(bid);
      bus.m_bresp_i  = 2'b00;
      tick();
      bus.atx_vld    = 1'b0;
      bus.m_bvalid_i = 1'b0;
      $display("alloc+bresp ch=%0d id=%0d bid=%0d done=%b busy=%b", ch, id, bid, atx_done, chn_busy);
   endtask

   initial begin
      int drain_id [6];
      int drain_ch [6];
      drain_id = '{10, 11, 13, 14, 15, 17};
      drain_ch = '{0, 1, 3, 0, 1, 3};

      bus.atx_vld = 1'b0; bus.atx_chn_id = '0; bus.atx_awid = '0;
      bus.m_bvalid_i = 1'b0; bus.m_bid_i = '0; bus.m_bresp_i = '0;

      // Reset state
      tick(); tick();
      chk("rst_done",  atx_done, 0);
      chk("rst_busy",  chn_busy, 0);
      chk("rst_unexp", unexp_bid, 0);
      chk("rst_rdy",   bus.atx_rdy, 1);
      chk("rst_bready", bus.m_bready_o, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_bready", bus.m_bready_o, 1);

      // Single transaction ch1/id3
      do_alloc(1, 3);
      chk("t1_busy", chn_busy, 4'b0010);
      do_b(3, 0);
      chk("t1_done", atx_done, 4'b0010);
      chk("t1_err",  atx_dst_err, 0);
      chk("t1_resp", atx_resp, 0);
      chk("t1_busy_drop", chn_busy, 0);
      tick();
      chk("t1_done_pulse", atx_done, 0);

      // Out-of-order across IDs
      do_alloc(0, 1);
      do_alloc(2, 2);
      chk("t2_busy", chn_busy, 4'b0101);
      do_b(2, 0);
      chk("t2_done_a", atx_done, 4'b0100);
      chk("t2_busy_a", chn_busy, 4'b0001);
      do_b(1, 0);
      chk("t2_done_b", atx_done, 4'b0001);
      chk("t2_busy_b", chn_busy, 0);
      chk("t2_unexp", unexp_bid, 0);

      // Same-ID ordering with error response
      do_alloc(0, 5);
      do_alloc(3, 5);
      do_b(5, 2);
      chk("t3_done_a", atx_done, 4'b0001);
      chk("t3_err_a",  atx_dst_err, 4'b0001);
      chk("t3_resp_a", atx_resp, 2'b10);
      do_b(5, 0);
      chk("t3_done_b", atx_done, 4'b1000);
      chk("t3_err_b",  atx_dst_err, 0);
      chk("t3_resp_b", atx_resp, 0);
      do_alloc(1, 9);
      do_b(9, 3);
      chk("t3_decerr", atx_dst_err, 4'b0010);
      chk("t3_decresp", atx_resp, 2'b11);

      // Fill table, overflow attempt, retire, concurrent alloc+retire
      for (int i = 0; i < 8; i++) do_alloc(i % 4, 10 + i);
      chk("t4_full_rdy", bus.atx_rdy, 0);
      chk("t4_full_busy", chn_busy, 4'b1111);
      do_alloc(2, 20);
      do_b(12, 0);
      chk("t4_ret_done", atx_done, 4'b0100);
      chk("t4_rdy_back", bus.atx_rdy, 1);
      chk("t4_busy2_a", chn_busy[2], 1);
      do_both(2, 21, 16);
      chk("t4_both_done", atx_done, 4'b0100);
      chk("t4_both_busy2", chn_busy[2], 1);
      chk("t4_both_rdy", bus.atx_rdy, 1);
      do_b(21, 0);
      chk("t4_id21_done", atx_done, 4'b0100);
      chk("t4_busy2_clear", chn_busy[2], 0);
      for (int i = 0; i < 6; i++) begin
         do_b(drain_id[i], 0);
         chk($sformatf("t4_drain_%0d", drain_id[i]), atx_done, 32'(1) << drain_ch[i]);
      end
      chk("t4_empty_busy", chn_busy, 0);
      chk("t4_unexp", unexp_bid, 0);

      // Unexpected BID and same-cycle alloc is not a match candidate
      do_b(7, 0);
      chk("t5_bready", bus.m_bready_o, 1);
      chk("t5_done", atx_done, 0);
      chk("t5_unexp", unexp_bid, 1);
      do_both(1, 30, 30);
      chk("t5_self_done", atx_done, 0);
      chk("t5_self_busy", chn_busy, 4'b0010);
      do_b(30, 0);
      chk("t5_late_done", atx_done, 4'b0010);
      chk("t5_unexp_sticky", unexp_bid, 1);

      // Mid-operation reset discards entries
      do_alloc(2, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_unexp", unexp_bid, 0);
      chk("t6_rst_busy", chn_busy, 0);
      tick();
      do_b(4, 0);
      chk("t6_discard_done", atx_done, 0);
      chk("t6_discard_unexp", unexp_bid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

`ifdef ADMA_BRESP_TIMEOUT_EN
      begin
         int early;
         early = 0;
         do_alloc(1, 6);
         for (int k = 1; k < 15; k++) begin
            tick();
            if (atx_timeout != 4'b0000) early++;
         end
         chk("t7_no_early_timeout", early, 0);
         tick();
         chk("t7_timeout", atx_timeout, 4'b0010);
         tick();
         chk("t7_timeout_once", atx_timeout, 0);
         do_b(6, 0);
         chk("t7_late_done", atx_done, 4'b0010);
      end
`else
      do_alloc(1, 6);
      for (int k = 0; k < 20; k++) tick();
      chk("t7_timeout_off", atx_timeout, 0);
      do_b(6, 0);
      chk("t7_late_done", atx_done, 4'b0010);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
